// File: rtl/cache_wb_axi_writer_if.sv
// cache_wb_axi_writer_if
// AXI4 write-channel bundle (AW, W, B) between the cache write-back bridge
// and the downstream memory interconnect.
//   master : bridge side, drives AW/W payload and valids, bready
//   slave  : interconnect side, drives awready, wready, bvalid (and bresp)
// When CACHE_WB_BRESP_CHECK_EN is defined the bundle also carries bresp.
interface cache_wb_axi_writer_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
`ifdef CACHE_WB_BRESP_CHECK_EN
  logic [1:0]  bresp;
`endif

  modport master (
`ifdef CACHE_WB_BRESP_CHECK_EN
    input  bresp,
`endif
    output awid, awaddr, awlen, awsize, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bvalid
  );

  modport slave (
`ifdef CACHE_WB_BRESP_CHECK_EN
    output bresp,
`endif
    input  awid, awaddr, awlen, awsize, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/cache_wb_axi_writer.sv
// cache_wb_axi_writer
// Converts one data-cache write request (a full line victim or an uncached
// byte/half/word store) into a single AXI4 write burst and pulses
// data_write_ok once the B response arrives. One transaction at a time.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   wr_req .. wr_data  cache write request (type 4 = line, 0/1/2 = uncached)
//   wr_rdy             bridge idle; request accepted this cycle if wr_req
//   data_write_ok      one-cycle pulse after the B handshake
//   axi                AXI4 write channels (master modport)
// Optional feature (macro CACHE_WB_BRESP_CHECK_EN): adds sticky wr_err,
// set by a B handshake carrying SLVERR/DECERR, cleared only by reset.
//
// state | meaning
// IDLE  | waiting for a request, wr_rdy high
// XFER  | AW and W channels in flight, progressing independently
// RESP  | burst sent, waiting for the B response
module cache_wb_axi_writer #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    data_write_ok,
`ifdef CACHE_WB_BRESP_CHECK_EN
  output logic                    wr_err,
`endif
  cache_wb_axi_writer_if.master   axi
);
  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t state;

  logic [LINE_WORDS-1:0][31:0] words_q;
  logic [CNT_W-1:0]            beat_cnt;
  logic [31:0]                 awaddr_q;
  logic [7:0]                  awlen_q;
  logic [2:0]                  awsize_q;
  logic [3:0]                  wstrb_q;
  logic                        awvalid_q, wvalid_q, bready_q;
  logic                        aw_done, w_done;
  logic                        aw_hs, w_hs, b_hs, wlast_c;

  assign aw_hs   = awvalid_q & axi.awready;
  assign w_hs    = wvalid_q & axi.wready;
  assign b_hs    = bready_q & axi.bvalid;
  assign wlast_c = (8'(beat_cnt) == awlen_q);
  assign wr_rdy  = resetn & (state == IDLE);

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = awsize_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = words_q[beat_cnt];
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = wlast_c;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      data_write_ok <= 1'b0;
      beat_cnt      <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awsize_q      <= '0;
      wstrb_q       <= '0;
`ifdef CACHE_WB_BRESP_CHECK_EN
      wr_err        <= 1'b0;
`endif
    end else begin
      data_write_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            words_q   <= wr_data;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            beat_cnt  <= '0;
            state     <= XFER;
            if (wr_type == 3'd4) begin
              awaddr_q <= {wr_addr[31:4], 4'b0};
              awlen_q  <= 8'(LINE_WORDS - 1);
              awsize_q <= 3'd2;
              wstrb_q  <= 4'hf;
            end else begin
              awaddr_q <= wr_addr;
              awlen_q  <= 8'd0;
              // type 3 and 5..7 are not legal; they fall back to a word store
              awsize_q <= (wr_type[2] | (&wr_type[1:0])) ? 3'd2 : {1'b0, wr_type[1:0]};
              wstrb_q  <= wr_wstrb;
            end
          end
        end
        XFER: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            if (wlast_c) begin
              wvalid_q <= 1'b0;
              w_done   <= 1'b1;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          // Look at this cycle's handshakes too, so the last of AW/W moves
          // straight to RESP and B can complete one cycle later.
          if ((aw_done | aw_hs) && (w_done | (w_hs & wlast_c))) begin
            bready_q <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            bready_q      <= 1'b0;
            data_write_ok <= 1'b1;
            state         <= IDLE;
`ifdef CACHE_WB_BRESP_CHECK_EN
            if (axi.bresp[1]) wr_err <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_wb_axi_writer.sv
module tb_cache_wb_axi_writer;
  logic         clk = 1'b0;
  logic         resetn;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         data_write_ok;
`ifdef CACHE_WB_BRESP_CHECK_EN
  logic         wr_err;
`endif

  cache_wb_axi_writer_if axi ();

  cache_wb_axi_writer dut (
    .clk           (clk),
    .resetn        (resetn),
    .wr_req        (wr_req),
    .wr_type       (wr_type),
    .wr_addr       (wr_addr),
    .wr_wstrb      (wr_wstrb),
    .wr_data       (wr_data),
    .wr_rdy        (wr_rdy),
    .data_write_ok (data_write_ok),
`ifdef CACHE_WB_BRESP_CHECK_EN
    .wr_err        (wr_err),
`endif
    .axi           (axi.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: expected bursts derived from the request alone.
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  aw_t aw_q[$];
  w_t  w_q[$];

  task automatic model_accept(input logic [2:0] t, input logic [31:0] a,
                              input logic [3:0] s, input logic [127:0] d);
    aw_t aw;
    w_t  w;
    int  n;
    if (t == 3'd4) begin
      aw.addr = a - (a % 16);
      aw.len  = 8'd3;
      aw.size = 3'd2;
      n = 4;
    end else begin
      aw.addr = a;
      aw.len  = 8'd0;
      aw.size = (t <= 3'd2) ? t : 3'd2;
      n = 1;
    end
    aw_q.push_back(aw);
    for (int k = 0; k < n; k++) begin
      w.data = d[32*k +: 32];
      w.strb = (t == 3'd4) ? 4'hf : s;
      w.last = (k == n - 1);
      w_q.push_back(w);
    end
  endtask

  int  cyc = 0;
  always @(posedge clk) cyc++;

  bit  busy = 0, ok_exp = 0, rst_prev = 0;
  int  acc_cnt = 0, ok_cnt = 0, acc_cyc = 0, ok_cyc = 0, aw_cyc = 0;
  int  w_cnt_txn = 0, w_before_aw = 0;
  bit  aw_stall_p = 0, w_stall_p = 0;
  logic [31:0] awaddr_p, wdata_p;
  logic [7:0]  awlen_p;
  logic [2:0]  awsize_p;
  logic [3:0]  wstrb_p;
  logic        wlast_p;

  // Monitor: sample between edges, check handshakes against the model.
  always @(negedge clk) begin
    aw_t ea;
    w_t  ew;
    bit  ok_next;
    ok_next = 0;
    if (!rst_prev) begin
      chk("rst_awvalid", axi.awvalid, 0);
      chk("rst_wvalid", axi.wvalid, 0);
      chk("rst_bready", axi.bready, 0);
    end
    chk("wr_rdy", wr_rdy, resetn && !busy);
    chk("data_write_ok", data_write_ok, ok_exp);
    if (data_write_ok) begin ok_cnt++; ok_cyc = cyc; end
    if (aw_stall_p) begin
      chk("aw_hold_valid", axi.awvalid, 1);
      chk("aw_hold_addr", axi.awaddr, awaddr_p);
      chk("aw_hold_len", axi.awlen, awlen_p);
      chk("aw_hold_size", axi.awsize, awsize_p);
    end
    if (w_stall_p) begin
      chk("w_hold_valid", axi.wvalid, 1);
      chk("w_hold_data", axi.wdata, wdata_p);
      chk("w_hold_strb", axi.wstrb, wstrb_p);
      chk("w_hold_last", axi.wlast, wlast_p);
    end
    if (resetn) begin
      if (wr_req && wr_rdy) begin
        model_accept(wr_type, wr_addr, wr_wstrb, wr_data);
        busy = 1; acc_cnt++; acc_cyc = cyc; w_cnt_txn = 0;
      end
      if (axi.awvalid && axi.awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          ea = aw_q.pop_front();
          chk("awaddr", axi.awaddr, ea.addr);
          chk("awlen", axi.awlen, ea.len);
          chk("awsize", axi.awsize, ea.size);
          chk("awid", axi.awid, 4'd1);
          aw_cyc = cyc; w_before_aw = w_cnt_txn;
        end
      end
      if (axi.wvalid && axi.wready) begin
        if (w_q.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          ew = w_q.pop_front();
          chk("wdata", axi.wdata, ew.data);
          chk("wstrb", axi.wstrb, ew.strb);
          chk("wlast", axi.wlast, ew.last);
          w_cnt_txn++;
        end
      end
      if (axi.bready) chk("bready_early", aw_q.size() + w_q.size(), 0);
      if (axi.bready && axi.bvalid) begin ok_next = 1; busy = 0; end
    end else begin
      aw_q.delete(); w_q.delete(); busy = 0;
    end
    ok_exp     = ok_next;
    aw_stall_p = resetn && axi.awvalid && !axi.awready;
    w_stall_p  = resetn && axi.wvalid && !axi.wready;
    awaddr_p = axi.awaddr; awlen_p = axi.awlen; awsize_p = axi.awsize;
    wdata_p = axi.wdata; wstrb_p = axi.wstrb; wlast_p = axi.wlast;
    rst_prev = resetn;
  end

  bit rnd = 0;
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      axi.awready = ($urandom_range(0, 3) != 0);
      axi.wready  = ($urandom_range(0, 3) != 0);
      axi.bvalid  = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic start_req(input logic [2:0] t, input logic [31:0] a,
                           input logic [3:0] s, input logic [127:0] d);
    int base, n;
    base = acc_cnt; n = 0;
    wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d; wr_req = 1'b1;
    while (acc_cnt == base && n < 200) begin tick(); n++; end
    if (acc_cnt == base) chk("accept_timeout", 0, 1);
    wr_req = 1'b0;
  endtask

  task automatic wait_ok(input int base);
    int n;
    n = 0;
    while (ok_cnt == base && n < 300) begin tick(); n++; end
    if (ok_cnt == base) chk("ok_timeout", 0, 1);
  endtask

  initial begin
    int b;
    resetn = 1'b0; wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
`ifdef CACHE_WB_BRESP_CHECK_EN
    axi.bresp = 2'b00;
`endif
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk("rdy_after_reset", wr_rdy, 1);

    // zero-wait line write
    axi.awready = 1; axi.wready = 1; axi.bvalid = 1;
    b = ok_cnt;
    start_req(3'd4, 32'h1C00_0124, 4'h0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    wait_ok(b);
    chk("line_latency", ok_cyc - acc_cyc, 6);
    tick();

    // uncached byte store
    b = ok_cnt;
    start_req(3'd0, 32'hBFAF_F003, 4'b1000, {96'h0, 32'hAB000000});
    wait_ok(b);
    chk("byte_latency", ok_cyc - acc_cyc, 3);
    tick();

    // AW held off for five cycles: all W beats go first
    axi.awready = 0;
    b = ok_cnt;
    start_req(3'd4, 32'h0000_1238, 4'h0, {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000});
    repeat (5) tick();
    axi.awready = 1;
    wait_ok(b);
    chk("aw_stall_w_first", w_before_aw, 4);
    chk("aw_stall_aw_cyc", aw_cyc - acc_cyc, 6);
    chk("aw_stall_latency", ok_cyc - acc_cyc, 8);
    chk("aw_stall_one_ok", ok_cnt - b, 1);
    tick();

    // wready toggling
    b = ok_cnt;
    start_req(3'd4, 32'h8000_0040, 4'h0, {32'h0F0F0F0F, 32'hF0F0F0F0, 32'h5A5A5A5A, 32'hA5A5A5A5});
    axi.wready = 1;
    for (int i = 0; i < 7; i++) begin tick(); axi.wready = ~axi.wready; end
    axi.wready = 1;
    wait_ok(b);
    chk("wtoggle_latency", ok_cyc - acc_cyc, 9);
    tick();

    // second request held during RESP
    axi.bvalid = 0;
    b = acc_cnt;
    start_req(3'd4, 32'h0000_2000, 4'h0, {32'h4, 32'h3, 32'h2, 32'h1});
    wr_type = 3'd2; wr_addr = 32'h0000_3004; wr_wstrb = 4'hf; wr_data = {96'h0, 32'hCAFEF00D};
    wr_req = 1;
    repeat (8) tick();
    chk("held_not_accepted", acc_cnt - b, 1);
    axi.bvalid = 1;
    for (int n = 0; n < 20 && acc_cnt - b < 2; n++) tick();
    wr_req = 0;
    chk("second_accept_cyc", acc_cyc, ok_cyc);
    b = ok_cnt;
    wait_ok(b);
    tick();

    // reset in the middle of XFER
    axi.wready = 0;
    b = ok_cnt;
    start_req(3'd4, 32'h0000_4000, 4'h0, {32'h9, 32'h8, 32'h7, 32'h6});
    repeat (2) tick();
    resetn = 0;
    repeat (2) tick();
    resetn = 1;
    repeat (3) tick();
    chk("rst_no_ok", ok_cnt, b);
    chk("rst_rdy_after", wr_rdy, 1);
    axi.wready = 1;

    // randomized traffic
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] t;
      t = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 7));
      b = ok_cnt;
      start_req(t, $urandom, 4'($urandom_range(0, 15)),
                {$urandom, $urandom, $urandom, $urandom});
      wait_ok(b);
      chk("rand_one_ok", ok_cnt - b, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd = 0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_wb_axi_writer.md
Name: cache_wb_axi_writer

Overview:
Write-side bridge directly downstream of the data cache's write port. Accepts one cache-line victim write-back (4 words) or one uncached store per request, and converts it into a single AXI4 write burst (AW/W/B). Returns `data_write_ok` to the cache after the B response. One transaction outstanding at a time.

Parameters:
LINE_WORDS, 4, words per cache line; `wr_data` width is 32*LINE_WORDS; cache-line bursts use `awlen` = LINE_WORDS-1
AXI_ID, 4'd1, constant value driven on `awid`

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
wr_req  in  1  cache write request
wr_type  in  3  0 byte, 1 half, 2 word, 4 cache line
wr_addr  in  32  write address
wr_wstrb  in  4  byte strobes (uncached only)
wr_data  in  128  line data; word k = bits [32k+31:32k]
wr_rdy  out  1  bridge idle, request accepted this cycle if `wr_req`
data_write_ok  out  1  one-cycle pulse: transaction's B response received
awid  out  4  = AXI_ID
awaddr  out  32  burst address
awlen  out  8  beats-1
awsize  out  3  bytes-per-beat code
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  write beat data
wstrb  out  4  write beat strobes
wlast  out  1  final beat
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Reset (`resetn`=0 at posedge): state IDLE. `awvalid`, `wvalid`, `bready`, `data_write_ok` = 0, beat counter = 0. `wr_rdy`=0 while `resetn` low, 1 in IDLE afterwards.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - `wr_rdy`=1.
  - On `wr_req`&&`wr_rdy`, latch addr/type/wstrb/data and go to XFER. `awvalid` and `wvalid` both rise the next cycle.
- Type decode at latch:
  - type 4: `awaddr` = {`wr_addr`[31:4],4'b0}; `awlen`=LINE_WORDS-1; `awsize`=2; every beat `wstrb`=4'hf.
  - type 2/1/0: `awaddr`=`wr_addr` unchanged; `awlen`=0; `awsize`=`wr_type`[1:0]; `wstrb`=latched `wr_wstrb`; `wdata` = `wr_data`[31:0].
  - Any other type is treated as type 2.
- XFER:
  - AW and W progress independently; W may complete before AW is accepted.
  - `awvalid` drops the cycle after `awvalid`&&`awready`; sticky `aw_done` is set.
  - Beat counter increments on each `wvalid`&&`wready`. `wdata` = latched word[counter]. `wlast` = (counter==`awlen`).
  - On the `wlast` handshake, `wvalid` drops and `w_done` is set.
  - When `aw_done`&&`w_done`, go to RESP.
  - All payload outputs hold stable while valid is high and ready is low.
- RESP:
  - `bready`=1.
  - On `bvalid`: `data_write_ok`=1 for exactly that following cycle, `bready` drops, go to IDLE.
  - `wr_rdy` is 1 again in the cycle after the B handshake.
- `wr_req` while not in IDLE is ignored (`wr_rdy`=0); the cache holds `wr_req` until accepted.
- Latency, zero wait states, line write:
  - accept at cycle 0;
  - AW and W0 handshake at cycle 1; W3 (`wlast`) at cycle 4;
  - B earliest at cycle 5;
  - `data_write_ok` at cycle 6.
- Beat counter wraps to 0 on leaving XFER. Never exceeds `awlen`.
- Reset mid-transaction aborts immediately: no `data_write_ok`, all valids low the next cycle.

Optional Feature:
Macro CACHE_WB_BRESP_CHECK_EN.
- Defined: adds input `bresp` [1:0] and output `wr_err` [0:0]. `wr_err` is set and held (cleared only by reset) if a B handshake carries `bresp`==2'b10 or 2'b11. `data_write_ok` still pulses.
- Undefined: neither port exists and no check is made.

Test Plan:
- Line write, `wr_addr`=0x1C00_0124, data words 0x11111111..0x44444444, ready always 1 -> `awaddr`=0x1C00_0120, `awlen`=3, `awsize`=2, `wdata` 0x11111111,0x22222222,0x33333333,0x44444444, `wlast` only on 4th beat, `data_write_ok` at cycle 6.
- Uncached byte store, `wr_type`=0, `wr_addr`=0xBFAF_F003, `wstrb`=4'b1000, `wr_data`[31:0]=0xAB000000 -> `awaddr`=0xBFAF_F003, `awlen`=0, `awsize`=0, one beat with `wlast`=1, `wstrb`=4'b1000.
- `awready` held low 5 cycles, `wready`=1 -> all 4 W beats finish first. AW accepted at cycle 6, then RESP. Exactly one `data_write_ok`.
- `wready` toggling 1,0,1,0 -> `wdata`/`wstrb`/`wlast` stable during stalls; counter advances only on handshakes.
- Second `wr_req` held high during RESP -> `wr_rdy`=0 until the cycle after the B handshake, then accepted. Reset asserted mid-XFER -> all valids 0, no `data_write_ok`, `wr_rdy`=1 after reset released.
